// File: rtl/cv32e40p_if_stage_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_if_ctrl_pkg
// Shared types for the IF-stage fetch/branch controller: the FSM state
// encoding and its width. Imported by the interface and the top module.
// ---------------------------------------------------------------------------
package cv32e40p_if_ctrl_pkg;

    localparam int IF_STATE_W = 2;

    // 2'd3 is not a legal encoding; the FSM falls back to IF_IDLE from it.
    typedef enum logic [1:0] {
        IF_IDLE    = 2'd0,
        IF_RUN     = 2'd1,
        IF_BR_WAIT = 2'd2
    } if_ctrl_state_e;

endpackage

// File: rtl/cv32e40p_if_stage_ctrl_if.sv
// ---------------------------------------------------------------------------
// cv32e40p_if_stage_ctrl_if
// Bundles the controller / prefetcher / aligner signals of the IF-stage
// fetch controller.
//   slave  : the controller side (consumes *_i, drives *_o)
//   master : the environment side (drives *_i, observes *_o)
// Parameters ADDR_W / CNT_W must match the controller instance using it.
// ---------------------------------------------------------------------------
interface cv32e40p_if_stage_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) ();
    import cv32e40p_if_ctrl_pkg::*;

    // Environment -> controller
    logic                  req_i;
    logic                  pc_set_i;
    logic [ADDR_W-1:0]     pc_target_i;
    logic                  branch_gnt_i;
    logic                  fetch_valid_i;
    logic                  if_valid_i;
    logic                  aligner_ready_i;
    logic                  cnt_clear_i;

    // Controller -> environment
    logic                  branch_req_o;
    logic [ADDR_W-1:0]     branch_addr_o;
    logic                  fetch_ready_o;
    logic                  perf_imiss_o;
    logic [CNT_W-1:0]      imiss_cnt_o;
    logic [IF_STATE_W-1:0] state_o;

    modport slave (
        input  req_i, pc_set_i, pc_target_i, branch_gnt_i,
               fetch_valid_i, if_valid_i, aligner_ready_i, cnt_clear_i,
        output branch_req_o, branch_addr_o, fetch_ready_o,
               perf_imiss_o, imiss_cnt_o, state_o
    );

    modport master (
        output req_i, pc_set_i, pc_target_i, branch_gnt_i,
               fetch_valid_i, if_valid_i, aligner_ready_i, cnt_clear_i,
        input  branch_req_o, branch_addr_o, fetch_ready_o,
               perf_imiss_o, imiss_cnt_o, state_o
    );

endinterface

// File: rtl/cv32e40p_if_stage_ctrl_perf_cnt.sv
// ---------------------------------------------------------------------------
// cv32e40p_perf_cnt
// Generic performance-event counter with synchronous clear.
//   clk, rst  : clock, asynchronous active-high reset
//   i_clear   : zero the counter next cycle (wins over i_event)
//   i_event   : count one event this cycle
//   o_count   : registered count
// CNT_SAT=1 sticks at all-ones, CNT_SAT=0 rolls over to zero.
// ---------------------------------------------------------------------------
module cv32e40p_perf_cnt #(
    parameter int CNT_W   = 16,
    parameter int CNT_SAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_event,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;

    // Natural overflow of the adder gives the wrapping behaviour; the
    // saturating flavour simply refuses to step past all-ones.
    generate
        if (CNT_SAT != 0) begin : g_sat
            assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        end else begin : g_wrap
            assign w_cnt_inc = r_cnt + 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_event) begin
            r_cnt <= w_cnt_inc;
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/cv32e40p_if_stage_ctrl.sv
// ---------------------------------------------------------------------------
// cv32e40p_if_stage_ctrl
// IF-stage fetch/branch controller. Forwards controller redirects to the
// prefetcher with zero latency, holds the request (and its target) until
// the prefetcher grants it, paces fetch pops to the aligner and counts
// instruction-miss cycles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of cv32e40p_if_stage_ctrl_if
//              in : req_i, pc_set_i, pc_target_i, branch_gnt_i,
//                   fetch_valid_i, if_valid_i, aligner_ready_i, cnt_clear_i
//              out: branch_req_o, branch_addr_o, fetch_ready_o,
//                   perf_imiss_o, imiss_cnt_o, state_o
// ---------------------------------------------------------------------------
module cv32e40p_if_stage_ctrl
    import cv32e40p_if_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 16,
    parameter int CNT_SAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    cv32e40p_if_stage_ctrl_if.slave bus
);

    if_ctrl_state_e    r_state;
    if_ctrl_state_e    w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_in_run;
    logic              w_in_wait;
    logic              w_branch_req;
    logic              w_imiss;
    logic [CNT_W-1:0]  w_cnt;

    assign w_in_run  = (r_state == IF_RUN);
    assign w_in_wait = (r_state == IF_BR_WAIT);

    // A fresh redirect bypasses the latch so the prefetcher sees it at once.
    assign w_addr_next = bus.pc_set_i ? bus.pc_target_i : r_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IF_IDLE;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            r_addr  <= w_addr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IF_IDLE, IF_RUN: begin
                // Ungranted redirect parks in BR_WAIT; otherwise (granted
                // redirect or no redirect) the core's fetch request alone
                // decides between RUN and IDLE.
                if (bus.pc_set_i && !bus.branch_gnt_i) begin
                    w_state_next = IF_BR_WAIT;
                end else begin
                    w_state_next = bus.req_i ? IF_RUN : IF_IDLE;
                end
            end
            IF_BR_WAIT: begin
                // A grant that coincides with a new redirect only retires
                // the old target; the new one still needs its own grant.
                if (!bus.pc_set_i && bus.branch_gnt_i) begin
                    w_state_next = bus.req_i ? IF_RUN : IF_IDLE;
                end
            end
            default: w_state_next = IF_IDLE;
        endcase
    end

    assign w_branch_req = bus.pc_set_i | w_in_wait;
    assign w_imiss      = w_branch_req | (w_in_run & bus.req_i & ~bus.fetch_valid_i);

    cv32e40p_perf_cnt #(
        .CNT_W   (CNT_W),
        .CNT_SAT (CNT_SAT)
    ) u_imiss_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.cnt_clear_i),
        .i_event (w_imiss),
        .o_count (w_cnt)
    );

    assign bus.branch_req_o  = w_branch_req;
    assign bus.branch_addr_o = w_addr_next;
    assign bus.fetch_ready_o = w_in_run & ~bus.pc_set_i & bus.fetch_valid_i & bus.req_i
                               & bus.if_valid_i & bus.aligner_ready_i;
    assign bus.perf_imiss_o  = w_imiss;
    assign bus.imiss_cnt_o   = w_cnt;
    assign bus.state_o       = r_state;

endmodule

// File: tb/tb_cv32e40p_if_stage_ctrl.sv
// Bench: three controller instances share one stimulus stream:
//   0: CNT_W=16 saturating, 1: CNT_W=4 saturating, 2: CNT_W=4 wrapping.
module tb_cv32e40p_if_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, pc_set, gnt, fv, ifv, ar, clr;
    logic [31:0] tgt;

    logic        o_breq [3];
    logic [31:0] o_addr [3];
    logic        o_fr   [3];
    logic        o_imiss[3];
    logic [15:0] o_cnt  [3];
    logic [1:0]  o_state[3];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int CW = (gi == 0) ? 16 : 4;
        localparam int CS = (gi == 2) ? 0 : 1;

        cv32e40p_if_stage_ctrl_if #(.ADDR_W(32), .CNT_W(CW)) bus ();

        assign bus.req_i           = req;
        assign bus.pc_set_i        = pc_set;
        assign bus.pc_target_i     = tgt;
        assign bus.branch_gnt_i    = gnt;
        assign bus.fetch_valid_i   = fv;
        assign bus.if_valid_i      = ifv;
        assign bus.aligner_ready_i = ar;
        assign bus.cnt_clear_i     = clr;

        cv32e40p_if_stage_ctrl #(.ADDR_W(32), .CNT_W(CW), .CNT_SAT(CS)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        assign o_breq[gi]  = bus.branch_req_o;
        assign o_addr[gi]  = bus.branch_addr_o;
        assign o_fr[gi]    = bus.fetch_ready_o;
        assign o_imiss[gi] = bus.perf_imiss_o;
        assign o_cnt[gi]   = 16'(bus.imiss_cnt_o);
        assign o_state[gi] = bus.state_o;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    // pending: a redirect has been issued but not yet granted.
    // active : outside a pending branch, the core is fetching.
    bit          m_pend, m_act;
    logic [31:0] m_addr;
    int unsigned m_cnt[3];
    int unsigned m_max[3] = '{65535, 15, 15};
    bit          m_sat[3] = '{1'b1, 1'b1, 1'b0};

    function automatic bit e_breq();  return pc_set | m_pend; endfunction
    function automatic bit e_imiss(); return e_breq() | (m_act & !m_pend & req & !fv); endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = 0; m_act = 0; m_addr = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end else begin
            bit miss;
            miss = e_imiss();
            for (int i = 0; i < 3; i++) begin
                if (clr)                     m_cnt[i] = 0;
                else if (miss) begin
                    if (m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
                    else if (!m_sat[i])      m_cnt[i] = 0;
                end
            end
            if (pc_set && !gnt) begin
                m_pend = 1;
            end else if (pc_set && gnt) begin
                if (!m_pend) m_act = req;
            end else if (m_pend) begin
                if (gnt) begin m_pend = 0; m_act = req; end
            end else begin
                m_act = req;
            end
            if (pc_set) m_addr = tgt;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("dut%0d state", i), 32'(o_state[i]),
                m_pend ? 32'd2 : (m_act ? 32'd1 : 32'd0));
            chk($sformatf("dut%0d branch_req", i), 32'(o_breq[i]), 32'(e_breq()));
            chk($sformatf("dut%0d branch_addr", i), o_addr[i], pc_set ? tgt : m_addr);
            chk($sformatf("dut%0d fetch_ready", i), 32'(o_fr[i]),
                32'(m_act & !m_pend & !pc_set & fv & req & ifv & ar));
            chk($sformatf("dut%0d perf_imiss", i), 32'(o_imiss[i]), 32'(e_imiss()));
            chk($sformatf("dut%0d imiss_cnt", i), 32'(o_cnt[i]), m_cnt[i]);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- directed stimulus with literal pins ----------------
    initial begin
        rst = 1; req = 0; pc_set = 0; gnt = 0; fv = 0; ifv = 0; ar = 0; clr = 0; tgt = 0;
        repeat (2) tick();
        #1;
        chk("rst state", 32'(o_state[0]), 0);
        chk("rst branch_req", 32'(o_breq[0]), 0);
        chk("rst branch_addr", o_addr[0], 0);
        chk("rst cnt", 32'(o_cnt[0]), 0);
        rst = 0;
        tick();

        // 1: start fetching
        req = 1; fv = 1; ifv = 1; ar = 1; #1;
        chk("t1 idle fetch_ready", 32'(o_fr[0]), 0);
        tick();
        chk("t1 run state", 32'(o_state[0]), 1);
        chk("t1 run fetch_ready", 32'(o_fr[0]), 1);
        repeat (3) tick();
        chk("t1 imiss", 32'(o_imiss[0]), 0);
        chk("t1 cnt", 32'(o_cnt[0]), 0);

        // 2: redirect held for 3 ungranted cycles then granted
        pc_set = 1; tgt = 32'h1A00; gnt = 0; #1;
        chk("t2 breq c1", 32'(o_breq[0]), 1);
        chk("t2 addr c1", o_addr[0], 32'h1A00);
        chk("t2 fr c1", 32'(o_fr[0]), 0);
        tick(); pc_set = 0; #1;
        chk("t2 state wait", 32'(o_state[0]), 2);
        chk("t2 addr held", o_addr[0], 32'h1A00);
        tick();
        tick(); gnt = 1; #1;
        chk("t2 breq c4", 32'(o_breq[0]), 1);
        chk("t2 fr c4", 32'(o_fr[0]), 0);
        tick(); gnt = 0; #1;
        chk("t2 state run", 32'(o_state[0]), 1);
        chk("t2 breq off", 32'(o_breq[0]), 0);
        for (int i = 0; i < 3; i++) chk($sformatf("t2 cnt dut%0d", i), 32'(o_cnt[i]), 4);

        // 3: redirect on top of a pending one, granted together
        pc_set = 1; tgt = 32'h100; gnt = 0;
        tick(); tgt = 32'h200; gnt = 1; #1;
        chk("t3 state wait", 32'(o_state[0]), 2);
        tick(); pc_set = 0; gnt = 0; #1;
        chk("t3 still wait", 32'(o_state[0]), 2);
        chk("t3 addr new", o_addr[0], 32'h200);
        tick(); gnt = 1;
        tick(); gnt = 0; #1;
        chk("t3 back run", 32'(o_state[0]), 1);
        chk("t3 cnt", 32'(o_cnt[0]), 8);

        // 4: granted redirect in RUN
        pc_set = 1; tgt = 32'h300; gnt = 1; #1;
        chk("t4 breq", 32'(o_breq[0]), 1);
        tick(); pc_set = 0; gnt = 0; #1;
        chk("t4 breq off", 32'(o_breq[0]), 0);
        chk("t4 state run", 32'(o_state[0]), 1);
        chk("t4 cnt", 32'(o_cnt[0]), 9);

        // 5: counter saturate / wrap / clear
        clr = 1;
        tick(); clr = 0; #1;
        for (int i = 0; i < 3; i++) chk($sformatf("t5 clr dut%0d", i), 32'(o_cnt[i]), 0);
        fv = 0;
        repeat (20) tick();
        fv = 1; #1;
        chk("t5 cnt16", 32'(o_cnt[0]), 20);
        chk("t5 cnt4 sat", 32'(o_cnt[1]), 32'hF);
        chk("t5 cnt4 wrap", 32'(o_cnt[2]), 32'h4);
        fv = 0; clr = 1;
        tick(); clr = 0; fv = 1; #1;
        for (int i = 0; i < 3; i++) chk($sformatf("t5 clr+miss dut%0d", i), 32'(o_cnt[i]), 0);

        // 6: asynchronous reset in BR_WAIT
        pc_set = 1; tgt = 32'h400; gnt = 0;
        tick(); pc_set = 0; #1;
        chk("t6 wait state", 32'(o_state[0]), 2);
        chk("t6 wait addr", o_addr[0], 32'h400);
        rst = 1; req = 0; #1;
        chk("t6 async state", 32'(o_state[0]), 0);
        chk("t6 async breq", 32'(o_breq[0]), 0);
        chk("t6 async addr", o_addr[0], 0);
        tick(); tick();
        rst = 0; req = 1; #1;
        chk("t6 rel state", 32'(o_state[0]), 0);
        chk("t6 rel breq", 32'(o_breq[0]), 0);
        tick();
        chk("t6 run state", 32'(o_state[0]), 1);
        chk("t6 run addr", o_addr[0], 0);
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cv32e40p_if_stage_ctrl.md
Name: cv32e40p_if_stage_ctrl

Overview:
Parametrised successor to the IF-stage fetch/branch control logic. It keeps the same zero-latency branch request and fetch-ready semantics, and adds the following:
- a registered FSM that holds a branch request until the prefetcher grants it;
- a latched branch target;
- gating of the instruction-miss indication to active fetch only;
- a configurable saturating or wrapping miss counter.

It sits between the controller (pc_set), the prefetch buffer (branch handshake, fetch_valid) and the aligner.

Parameters:
ADDR_W, 32, width of branch target address.
CNT_W, 16, width of instruction-miss counter.
CNT_SAT, 1, 1 = counter saturates at all-ones; 0 = counter wraps to 0.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_i  input  1  core requests instruction fetch
pc_set_i  input  1  controller redirects PC this cycle
pc_target_i  input  ADDR_W  new PC, valid with pc_set_i
branch_gnt_i  input  1  prefetcher accepts branch request
fetch_valid_i  input  1  prefetcher has instruction data
if_valid_i  input  1  IF stage may advance
aligner_ready_i  input  1  aligner can accept data
cnt_clear_i  input  1  synchronous clear of miss counter
branch_req_o  output  1  branch request to prefetcher
branch_addr_o  output  ADDR_W  branch target to prefetcher
fetch_ready_o  output  1  pop one fetch entry
perf_imiss_o  output  1  instruction-miss event this cycle
imiss_cnt_o  output  CNT_W  accumulated miss count
state_o  output  2  current FSM state (debug)

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE, addr_q=0, cnt_q=0.
  - With pc_set_i=0, all 1-bit outputs read 0, branch_addr_o=0, imiss_cnt_o=0.
- FSM states: IDLE=2'd0, RUN=2'd1, BR_WAIT=2'd2. Value 2'd3 is illegal and recovers to IDLE on the next clock.
- branch_req_o = pc_set_i | (state==BR_WAIT). This is combinational, so there is zero latency on a new redirect.
- branch_addr_o = pc_set_i ? pc_target_i : addr_q.
- addr_q loads pc_target_i on every cycle with pc_set_i=1.
- Transitions, evaluated in priority order:
  - pc_set_i=1 and branch_gnt_i=0 -> BR_WAIT (from any state).
  - pc_set_i=1 and branch_gnt_i=1:
    - from IDLE or RUN: the branch completes the same cycle; next state is RUN if req_i, else IDLE.
    - from BR_WAIT: the old branch is consumed by the grant; the new target is latched and the FSM stays in BR_WAIT.
  - BR_WAIT with branch_gnt_i=1 and pc_set_i=0 -> RUN if req_i, else IDLE.
  - IDLE with req_i=1 -> RUN.
  - RUN with req_i=0 -> IDLE.
  - Otherwise the state holds.
- branch_req_o held high in BR_WAIT: branch_addr_o is stable and equal to addr_q until granted.
- fetch_ready_o = (state==RUN) & !pc_set_i & fetch_valid_i & req_i & if_valid_i & aligner_ready_i.
  - Never asserted in IDLE or BR_WAIT.
  - Never asserted in the same cycle as branch_req_o.
- perf_imiss_o = branch_req_o | ((state==RUN) & req_i & !fetch_valid_i).
  - An idle core (req_i=0) never counts a miss.
- Counter update:
  - cnt_clear_i=1 -> cnt_q=0 next cycle. Clear has priority over increment.
  - Else perf_imiss_o=1 -> cnt_q+1.
  - At all-ones: CNT_SAT=1 holds the value; CNT_SAT=0 wraps to 0.
  - imiss_cnt_o = cnt_q (registered, one-cycle latency after the event).
- Reset mid-branch (rst during BR_WAIT):
  - The FSM returns to IDLE immediately and addr_q clears.
  - After reset deassertion there is no lingering request unless pc_set_i is set.
- Bench contract: pc_set_i and req_i are held low while rst=1.

Decomposition:
- Package cv32e40p_if_ctrl_pkg:
  - typedef enum logic [1:0] if_ctrl_state_e {IF_IDLE, IF_RUN, IF_BR_WAIT};
  - localparam IF_STATE_W = 2.
- Sub-module cv32e40p_perf_cnt: parametrised CNT_W/CNT_SAT event counter with clear. It is reusable for other perf events.
- The FSM and combinational outputs stay in the top module.

Test Plan:
1. Reset, then req_i=1 with fetch_valid_i=if_valid_i=aligner_ready_i=1:
   - cycle 1: state IDLE->RUN, fetch_ready_o=0.
   - from cycle 2: fetch_ready_o=1 every cycle, perf_imiss_o=0, imiss_cnt_o stays 0.
2. In RUN, pc_set_i=1, pc_target_i=32'h0000_1A00, branch_gnt_i=0 for 3 cycles then 1:
   - branch_req_o=1 for 4 cycles; branch_addr_o=32'h1A00 throughout.
   - fetch_ready_o=0 throughout.
   - FSM returns to RUN after the grant; imiss_cnt_o=4.
3. In BR_WAIT (target 32'h100), pc_set_i=1 with target 32'h200 and branch_gnt_i=1 in the same cycle:
   - FSM stays in BR_WAIT; next-cycle branch_addr_o=32'h200.
   - The next grant returns the FSM to RUN.
4. pc_set_i=1 with branch_gnt_i=1 in RUN (single cycle):
   - branch_req_o=1 for 1 cycle only; FSM stays in RUN; counter +1.
5. CNT_W=4:
   - CNT_SAT=1: 20 miss cycles -> imiss_cnt_o=4'hF.
   - CNT_SAT=0: 20 miss cycles -> imiss_cnt_o=4'h4.
   - cnt_clear_i together with a miss -> imiss_cnt_o=0.
6. Assert rst asynchronously mid-BR_WAIT (between clock edges):
   - state_o=0 and branch_req_o=0 immediately.
   - After release with req_i=1, the FSM enters RUN one cycle later and branch_addr_o=0.
